// File: rtl/rr_stream_mux.sv
// Registered N-channel stream multiplexer with a round-robin arbiter and optional word inversion.
// A single output register refills in the same cycle it drains, so a busy stream has no bubbles.
module rr_stream_mux #(
  parameter int N_CH = 4,
  parameter int W    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         in_valid,
  input  logic [N_CH*W-1:0]       in_data,
  output logic [N_CH-1:0]         in_ready,
  input  logic                    invert,
  output logic                    out_valid,
  output logic [W-1:0]            out_data,
  output logic [$clog2(N_CH)-1:0] out_ch,
  input  logic                    out_ready
);

  localparam int CW = $clog2(N_CH);

  logic [CW-1:0] ptr;
  logic [CW-1:0] grant;
  logic          load;
  logic          found;
  logic [W-1:0]  sel_data;

  // Scan starts just after the last winner, so the last winner has the lowest priority.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      if (!found && in_valid[(int'(ptr) + k) % N_CH]) begin
        grant = CW'((int'(ptr) + k) % N_CH);
        found = 1'b1;
      end
    end
  end

  assign load     = (!out_valid || out_ready) && (|in_valid);
  assign sel_data = in_data[int'(grant)*W +: W];

  always_comb begin
    in_ready = '0;
    if (load) in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= CW'(N_CH - 1);
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= invert ? ~sel_data : sel_data;
      out_ch    <= grant;
      ptr       <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
